// File: rtl/locker_top.sv
// Six-button combination lock with a multiplexed six-digit seven-segment display.
// Collects six presses, compares them to COMBO and latches success/wrong until reset.
module locker_top #(
  parameter logic [17:0] COMBO    = 18'o543210,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTNA,
  input  logic       BTNB,
  input  logic       BTNC,
  input  logic       BTND,
  input  logic       BTNE,
  input  logic       BTNF,
  output logic       SUCESS_COMB_LED,
  output logic       WRONG_COMB_LED,
  output logic [5:0] ANODE,
  output logic [6:0] SEGMENTS
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {ENTRY, DONE} state_t;

  state_t state, state_next;

  logic [5:0] btn_raw;
  logic [5:0] btn_q;
  logic [5:0] btn_qq;
  logic [5:0] held;
  logic [5:0] press;
  logic       press_valid;
  logic [2:0] press_code;

  logic [5:0][2:0] slot_code;
  logic [5:0]      slot_full;
  logic [2:0]      count;
  logic            match;

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit;
  logic [2:0]        digit_next;
  logic              scan_wrap;

  function automatic logic [2:0] combo_at(input logic [2:0] idx);
    case (idx)
      3'd0:    combo_at = COMBO[2:0];
      3'd1:    combo_at = COMBO[5:3];
      3'd2:    combo_at = COMBO[8:6];
      3'd3:    combo_at = COMBO[11:9];
      3'd4:    combo_at = COMBO[14:12];
      3'd5:    combo_at = COMBO[17:15];
      default: combo_at = 3'd7;
    endcase
  endfunction

  function automatic logic [6:0] glyph(input logic [2:0] code);
    case (code)
      3'd0:    glyph = 7'h08;
      3'd1:    glyph = 7'h03;
      3'd2:    glyph = 7'h46;
      3'd3:    glyph = 7'h21;
      3'd4:    glyph = 7'h06;
      3'd5:    glyph = 7'h0E;
      3'd7:    glyph = 7'h3F;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign btn_raw = {BTNF, BTNE, BTND, BTNC, BTNB, BTNA};

  // A button still held when reset releases stays masked until it is seen low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_q  <= '0;
      btn_qq <= '0;
      held   <= 6'h3F;
    end else begin
      btn_q  <= btn_raw;
      btn_qq <= btn_q;
      held   <= held & btn_raw;
    end
  end

  assign press       = btn_q & ~btn_qq & ~held;
  assign press_valid = |press;

  always_comb begin
    press_code = 3'd7;
    case (press)
      6'b000001: press_code = 3'd0;
      6'b000010: press_code = 3'd1;
      6'b000100: press_code = 3'd2;
      6'b001000: press_code = 3'd3;
      6'b010000: press_code = 3'd4;
      6'b100000: press_code = 3'd5;
      default:   press_code = 3'd7;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ENTRY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ENTRY:   if (press_valid && count == 3'd5) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = ENTRY;
    endcase
  end

  always_comb begin
    SUCESS_COMB_LED = 1'b0;
    WRONG_COMB_LED  = 1'b0;
    if (state == DONE) begin
      SUCESS_COMB_LED = match;
      WRONG_COMB_LED  = ~match;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_code <= '0;
      slot_full <= '0;
      count     <= '0;
      match     <= 1'b1;
    end else if (state == ENTRY && press_valid) begin
      slot_code[count] <= press_code;
      slot_full[count] <= 1'b1;
      count            <= count + 3'd1;
      if (press_code != combo_at(count)) match <= 1'b0;
    end
  end

  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    digit_next = digit;
    if (scan_wrap) digit_next = (digit == 3'd5) ? 3'd0 : digit + 3'd1;
  end

  // Anode and segments are both loaded from digit_next so they switch together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt <= '0;
      digit    <= '0;
      ANODE    <= 6'b011111;
      SEGMENTS <= 7'h7F;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      digit    <= digit_next;
      ANODE    <= ~(6'b100000 >> digit_next);
      SEGMENTS <= slot_full[digit_next] ? glyph(slot_code[digit_next]) : 7'h7F;
    end
  end

endmodule

// File: tb/tb_locker_top.sv
// Self-checking bench for locker_top: directed scenarios plus random presses,
// compared every cycle against a behavioural model of the lock and display.
module tb_locker_top;

  localparam int          SCAN_DIV = 16;
  localparam logic [17:0] COMBO    = 18'o543210;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] btn = '0;
  logic       sucess_led;
  logic       wrong_led;
  logic [5:0] anode;
  logic [6:0] segments;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  locker_top #(.COMBO(COMBO), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK(CLK),
    .RST(RST),
    .BTNA(btn[0]),
    .BTNB(btn[1]),
    .BTNC(btn[2]),
    .BTND(btn[3]),
    .BTNE(btn[4]),
    .BTNF(btn[5]),
    .SUCESS_COMB_LED(sucess_led),
    .WRONG_COMB_LED(wrong_led),
    .ANODE(anode),
    .SEGMENTS(segments)
  );

  function automatic logic [6:0] glyph_of(input int code);
    case (code)
      0:       return 7'h08;
      1:       return 7'h03;
      2:       return 7'h46;
      3:       return 7'h21;
      4:       return 7'h06;
      5:       return 7'h0E;
      7:       return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int combo_digit(input int i);
    return int'((COMBO >> (3 * i)) & 18'h7);
  endfunction

  // Model: list of recorded entries, the list as the display last latched it,
  // and cycles elapsed since reset for the scan position.
  int         m_entries[$];
  int         m_shown[$];
  bit         m_done  = 1'b0;
  bit         m_ok    = 1'b0;
  bit         m_valid = 1'b0;
  int         m_t     = 0;
  logic [5:0] m_s1, m_s2, m_held;

  always @(posedge CLK) begin : model
    logic [5:0] ev;
    int         code;
    if (RST) begin
      m_entries.delete();
      m_shown.delete();
      m_done  = 1'b0;
      m_ok    = 1'b0;
      m_t     = 0;
      m_s1    = '0;
      m_s2    = '0;
      m_held  = 6'h3F;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_shown = m_entries;
      ev = m_s1 & ~m_s2 & ~m_held;
      if (ev != 0 && !m_done) begin
        code = 7;
        if ($countones(ev) == 1)
          for (int i = 0; i < 6; i++) if (ev[i]) code = i;
        m_entries.push_back(code);
        if (m_entries.size() == 6) begin
          m_done = 1'b1;
          m_ok   = 1'b1;
          for (int i = 0; i < 6; i++)
            if (m_entries[i] != combo_digit(i)) m_ok = 1'b0;
        end
      end
      m_held = m_held & btn;
      m_s2   = m_s1;
      m_s1   = btn;
      m_t++;
    end
  end

  always @(negedge CLK) begin : compare
    int         d;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_s, exp_w;
    if (m_valid) begin
      d = (m_t / SCAN_DIV) % 6;
      exp_an = 6'h3F;
      exp_an[5 - d] = 1'b0;
      exp_seg = (d < m_shown.size()) ? glyph_of(m_shown[d]) : 7'h7F;
      exp_s = m_done && m_ok;
      exp_w = m_done && !m_ok;
      n_checks++;
      if ({sucess_led, wrong_led, anode, segments} === {exp_s, exp_w, exp_an, exp_seg})
        n_pass++;
      else
        $display("[TB] FAIL cycle_model t=%0d got led=%b%b an=%b seg=%h want led=%b%b an=%b seg=%h",
                 m_t, sucess_led, wrong_led, anode, segments, exp_s, exp_w, exp_an, exp_seg);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
  endtask

  task automatic doReset(input int n);
    @(negedge CLK);
    RST = 1'b1;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic applyStimulus(input logic [5:0] mask, input int hold);
    @(negedge CLK);
    btn = mask;
    repeat (hold) @(negedge CLK);
    btn = '0;
    @(negedge CLK);
  endtask

  task automatic pressSeq(input int c0, input int c1, input int c2,
                          input int c3, input int c4, input int c5);
    int codes[6];
    codes = '{c0, c1, c2, c3, c4, c5};
    for (int i = 0; i < 6; i++) applyStimulus(6'(1 << codes[i]), 1);
  endtask

  task automatic checkDigit(input int d, input logic [6:0] seg, input string name);
    logic [5:0] want_an;
    int         waited;
    want_an = 6'h3F;
    want_an[5 - d] = 1'b0;
    @(negedge CLK);
    waited = 0;
    while (anode !== want_an && waited < 8 * SCAN_DIV) begin
      @(negedge CLK);
      waited++;
    end
    if (anode !== want_an) checkOutput({name, "_scan_timeout"}, 32'(anode), 32'(want_an));
    else checkOutput(name, 32'(segments), 32'(seg));
  endtask

  initial begin
    doReset(2);
    checkOutput("reset_anode", 32'(anode), 32'h1F);
    checkOutput("reset_segments", 32'(segments), 32'h7F);
    checkOutput("reset_leds", 32'({sucess_led, wrong_led}), 32'h0);
    repeat (15) @(negedge CLK);
    checkOutput("scan_hold_15", 32'(anode), 32'h1F);
    @(negedge CLK);
    checkOutput("scan_step_16", 32'(anode), 32'h2F);

    pressSeq(0, 1, 2, 3, 4, 5);
    checkOutput("ok_sucess_led", 32'(sucess_led), 32'h1);
    checkOutput("ok_wrong_led", 32'(wrong_led), 32'h0);
    checkDigit(0, 7'h08, "ok_digit0_A");
    checkDigit(1, 7'h03, "ok_digit1_b");
    checkDigit(2, 7'h46, "ok_digit2_C");
    checkDigit(3, 7'h21, "ok_digit3_d");
    checkDigit(4, 7'h06, "ok_digit4_E");
    checkDigit(5, 7'h0E, "ok_digit5_F");

    applyStimulus(6'b000010, 1);
    applyStimulus(6'b000100, 2);
    checkOutput("done_ignores_leds", 32'({sucess_led, wrong_led}), 32'h2);
    checkDigit(0, 7'h08, "done_ignores_digit0");
    doReset(1);
    checkOutput("rst_done_leds", 32'({sucess_led, wrong_led}), 32'h0);
    checkOutput("rst_done_anode", 32'(anode), 32'h1F);
    checkOutput("rst_done_segments", 32'(segments), 32'h7F);
    checkDigit(2, 7'h7F, "rst_done_digit2_blank");

    doReset(1);
    pressSeq(0, 0, 2, 3, 4, 5);
    checkOutput("bad_leds", 32'({sucess_led, wrong_led}), 32'h1);
    checkDigit(1, 7'h08, "bad_digit1_A");

    doReset(1);
    applyStimulus(6'b000011, 1);
    applyStimulus(6'b000100, 1);
    applyStimulus(6'b001000, 1);
    applyStimulus(6'b010000, 1);
    applyStimulus(6'b100000, 1);
    applyStimulus(6'b000001, 1);
    checkOutput("multi_leds", 32'({sucess_led, wrong_led}), 32'h1);
    checkDigit(0, 7'h3F, "multi_digit0_dash");

    doReset(1);
    applyStimulus(6'b000001, 5);
    checkDigit(0, 7'h08, "hold_digit0_A");
    checkDigit(1, 7'h7F, "hold_digit1_blank");
    applyStimulus(6'b000010, 1);
    applyStimulus(6'b000100, 1);
    doReset(1);
    checkDigit(0, 7'h7F, "midrst_digit0_blank");
    pressSeq(0, 1, 2, 3, 4, 5);
    checkOutput("midrst_then_ok_leds", 32'({sucess_led, wrong_led}), 32'h2);

    @(negedge CLK);
    btn = 6'b000001;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    btn = '0;
    checkDigit(0, 7'h7F, "held_thru_rst_no_entry");
    pressSeq(0, 1, 2, 3, 4, 5);
    checkOutput("held_thru_rst_then_ok", 32'({sucess_led, wrong_led}), 32'h2);

    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) doReset($urandom_range(1, 2));
      else if (r < 6) pressSeq(0, 1, 2, 3, 4, 5);
      else if (r < 14) applyStimulus(6'($urandom_range(0, 63)), $urandom_range(1, 3));
      else applyStimulus(6'(1 << $urandom_range(0, 5)), $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
